// File: rtl/buffer_fill_ctrl.sv
// -----------------------------------------------------------------------------
// buffer_fill_ctrl
//
// Upstream controller for a 4-row x 16-byte sliding-window line buffer.
//
// Frame sequence:
//   1. Fetch image rows 0..3 (16 words, one outstanding read at a time) into
//      buffer rows 0..3.
//   2. Sweep buf_table_index 3..15 under a win_valid/win_ready handshake.
//   3. Between bands, pulse buf_shift_en once and refill buffer row 3 with the
//      next image row.
//   4. Repeat from the sweep until all IMG_ROWS image rows have been consumed.
//
// Image row r, word c lives at word address base_addr + 4*r + c, and the
// address wraps modulo 2**ADDR_W.
//
// Parameters
//   ADDR_W    memory word-address width
//   IMG_ROWS  image height in rows (4..1024), each row is 4 words
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   start            begin a frame (sampled only while idle)
//   base_addr        word address of image row 0 word 0, latched on start
//   busy, done       frame in progress / one-cycle completion pulse
//   mem_req          one-cycle read request pulse
//   mem_addr         read address, valid with mem_req (0 otherwise)
//   mem_rvalid       read data valid
//   mem_rdata        read data, byte [31:24] is the leftmost pixel
//   buf_ld           buffer load strobe (registered)
//   buf_row          target buffer row for the load
//   buf_col          target word column for the load
//   buf_data         word to load
//   buf_shift_en     buffer row-shift strobe
//   buf_table_index  rightmost column of the current window
//   win_valid        window available to the consumer
//   win_ready        consumer accepts the window
//   stall_cnt        stall performance counter
//
// Configuration macro
//   BUF_FILL_STALL_CNT_EN  when defined, stall_cnt counts cycles with a
//                          window stalled by the consumer or a read waiting
//                          on memory. The count saturates and clears on reset
//                          and on an accepted start. When the macro is not
//                          defined, stall_cnt is tied to 0.
// -----------------------------------------------------------------------------
module buffer_fill_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int IMG_ROWS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              buf_ld,
    output logic              buf_shift_en,
    output logic [1:0]        buf_row,
    output logic [1:0]        buf_col,
    output logic [31:0]       buf_data,
    output logic [3:0]        buf_table_index,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [15:0]       stall_cnt
);

    localparam logic [4:0]  FILL_WORDS       = 5'd16;
    localparam logic [4:0]  ROW_WORDS        = 5'd4;
    localparam logic [10:0] ROWS_LIMIT       = 11'(IMG_ROWS);
    localparam logic [10:0] FIRST_REFILL_ROW = 11'd4;
    localparam logic [3:0]  IDX_FIRST        = 4'd3;
    localparam logic [3:0]  IDX_LAST         = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_SETTLE,
        S_SWEEP,
        S_SHIFT,
        S_REFILL,
        S_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [ADDR_W-1:0] base_q;        // latched frame base address
    logic [10:0]       next_row_q;    // next image row to be refilled
    logic [4:0]        req_cnt_q;     // reads issued in the current fetch phase
    logic [4:0]        ld_cnt_q;      // reads returned in the current fetch phase
    logic              rd_pending_q;  // one read is outstanding

    logic              start_ok;
    logic              fetching;
    logic [4:0]        fetch_words;
    logic [10:0]       fetch_row;
    logic [ADDR_W-1:0] fetch_addr;
    logic              rd_accept;
    logic              win_fire;

    assign start_ok    = (state_q == S_IDLE) && start;
    assign fetching    = (state_q == S_FILL) || (state_q == S_REFILL);
    assign fetch_words = (state_q == S_FILL) ? FILL_WORDS : ROW_WORDS;

    // The initial fill reads rows 0..3 as one linear run of 16 words starting
    // at the base address. A refill reads the 4 words of next_row_q.
    assign fetch_row   = (state_q == S_FILL) ? 11'd0 : next_row_q;
    assign fetch_addr  = base_q + ADDR_W'({fetch_row, 2'b00}) + ADDR_W'(req_cnt_q);

    // Returned data is only meaningful while a read is outstanding. A stray
    // valid (while idle, or after a reset abort) must not produce a load.
    assign rd_accept   = rd_pending_q && mem_rvalid;
    assign win_fire    = win_valid && win_ready;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every register samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and Moore-style control outputs
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case statement.
    // A path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d      = state_q;
        busy         = (state_q != S_IDLE);
        done         = 1'b0;
        mem_req      = 1'b0;
        buf_shift_en = 1'b0;
        win_valid    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FILL;
                end
            end

            S_FILL, S_REFILL: begin
                // Issue the next read only after the previous one has returned.
                mem_req = !rd_pending_q && (req_cnt_q < fetch_words);
                // ld_cnt_q already counts the word being loaded this cycle, so
                // the phase ends in the cycle of its last buf_ld.
                if (buf_ld && (ld_cnt_q == fetch_words)) begin
                    state_d = S_SETTLE;
                end
            end

            S_SETTLE: begin
                state_d = S_SWEEP;
            end

            S_SWEEP: begin
                win_valid = 1'b1;
                if (win_ready && (buf_table_index == IDX_LAST)) begin
                    state_d = (next_row_q < ROWS_LIMIT) ? S_SHIFT : S_DONE;
                end
            end

            S_SHIFT: begin
                buf_shift_en = 1'b1;
                state_d      = S_REFILL;
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The address bus is held at 0 whenever no request is being made.
    assign mem_addr = mem_req ? fetch_addr : '0;

    // -------------------------------------------------------------------------
    // Fetch bookkeeping, load path and window index
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q          <= '0;
            next_row_q      <= '0;
            req_cnt_q       <= '0;
            ld_cnt_q        <= '0;
            rd_pending_q    <= 1'b0;
            buf_ld          <= 1'b0;
            buf_row         <= '0;
            buf_col         <= '0;
            buf_data        <= '0;
            buf_table_index <= '0;
        end else begin
            buf_ld <= 1'b0;

            if (start_ok) begin
                base_q     <= base_addr;
                next_row_q <= FIRST_REFILL_ROW;
                req_cnt_q  <= '0;
                ld_cnt_q   <= '0;
            end

            // Single-outstanding protocol. mem_req only fires with nothing
            // pending, so issue and return never coincide.
            if (mem_req) begin
                rd_pending_q <= 1'b1;
                req_cnt_q    <= req_cnt_q + 5'd1;
            end else if (rd_accept) begin
                rd_pending_q <= 1'b0;
            end

            // Data returns in order, so the return count gives the target
            // slot. The fill walks rows 0..3; a refill always targets row 3.
            if (rd_accept) begin
                buf_ld   <= 1'b1;
                buf_data <= mem_rdata;
                buf_row  <= (state_q == S_FILL) ? ld_cnt_q[3:2] : 2'd3;
                buf_col  <= ld_cnt_q[1:0];
                ld_cnt_q <= ld_cnt_q + 5'd1;
            end

            // Start the refill phase counters from zero.
            if (state_q == S_SHIFT) begin
                req_cnt_q <= '0;
                ld_cnt_q  <= '0;
            end

            // A completed refill consumes one more image row. The end-of-band
            // test then compares the following row against IMG_ROWS.
            if ((state_q == S_REFILL) && (state_d == S_SETTLE)) begin
                next_row_q <= next_row_q + 11'd1;
            end

            if (state_q == S_SETTLE) begin
                buf_table_index <= IDX_FIRST;
            end else if (win_fire && (buf_table_index != IDX_LAST)) begin
                buf_table_index <= buf_table_index + 4'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stall performance counter
    // -------------------------------------------------------------------------
`ifdef BUF_FILL_STALL_CNT_EN
    logic stall_evt;

    assign stall_evt = (win_valid && !win_ready) || (rd_pending_q && !mem_rvalid);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (start_ok) begin
            stall_cnt <= '0;
        end else if (stall_evt && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = 16'h0000;
`endif

    // -------------------------------------------------------------------------
    // Protocol invariants
    // -------------------------------------------------------------------------
`ifndef SYNTHESIS
    a_ld_shift_excl : assert property (@(posedge clk) disable iff (rst)
        !(buf_ld && buf_shift_en));
    a_win_excl : assert property (@(posedge clk) disable iff (rst)
        !(win_valid && (buf_ld || buf_shift_en)));
    a_one_read : assert property (@(posedge clk) disable iff (rst)
        !(mem_req && rd_pending_q));
`endif

endmodule

// File: tb/tb_buffer_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_buffer_fill_ctrl
//
// Directed bench for buffer_fill_ctrl with IMG_ROWS = 6 (3 bands per frame).
// A table of frame records supplies the stimulus and the hand-computed
// expected totals. Each frame's log is also compared against the address
// formula base + i (with 16-bit wrap), against the buffer row/column
// placement, and against the cycle relations between start, loads, windows,
// shifts and done. Hand-written sequences cover reset, a stray read-valid
// while idle, and a reset during a refill.
//
// All sampling and driving happens at the falling edge. Window acceptance is
// recorded just before advancing, once the inputs for that cycle are final.
// -----------------------------------------------------------------------------
module tb_buffer_fill_ctrl;

    localparam int ROWS = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic        busy;
    logic        done;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        buf_ld;
    logic        buf_shift_en;
    logic [1:0]  buf_row;
    logic [1:0]  buf_col;
    logic [31:0] buf_data;
    logic [3:0]  buf_table_index;
    logic        win_valid;
    logic        win_ready;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    buffer_fill_ctrl #(
        .ADDR_W   (16),
        .IMG_ROWS (ROWS)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .base_addr       (base_addr),
        .busy            (busy),
        .done            (done),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .buf_ld          (buf_ld),
        .buf_shift_en    (buf_shift_en),
        .buf_row         (buf_row),
        .buf_col         (buf_col),
        .buf_data        (buf_data),
        .buf_table_index (buf_table_index),
        .win_valid       (win_valid),
        .win_ready       (win_ready),
        .stall_cnt       (stall_cnt)
    );

    // ---------------------------------------------------------------- checking
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_data(input logic [15:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    // ------------------------------------------------------- logs and memory
    logic [15:0] req_q[$];
    int          req_cyc_q[$];
    logic [35:0] ld_q[$];       // {row, col, data}
    int          ld_cyc_q[$];
    int          win_q[$];
    int          acc15_q[$];
    int          shift_q[$];
    int          vrise_q[$];
    int          done_cnt    = 0;
    int          done_cyc    = 0;
    int          overlap_err = 0;
    int          excl_err    = 0;
    logic        prev_valid  = 1'b0;

    int          pend_cnt  = 0;   // cycles until the memory model answers
    logic [15:0] pend_addr = '0;
    logic        inject    = 1'b0;
    int          lat_min   = 1;
    int          lat_max   = 1;

    task automatic clear_logs();
        req_q.delete();  req_cyc_q.delete();
        ld_q.delete();   ld_cyc_q.delete();
        win_q.delete();  acc15_q.delete();
        shift_q.delete(); vrise_q.delete();
        overlap_err = 0;
        excl_err    = 0;
    endtask

    // Advance one cycle: record this cycle's handshake, move to the next
    // falling edge, log outputs, then drive the memory model.
    task automatic tick();
        if (win_valid && win_ready) begin
            win_q.push_back(int'(buf_table_index));
            if (buf_table_index == 4'd15) acc15_q.push_back(cyc);
        end
        @(negedge clk);
        if (mem_req) begin
            if (pend_cnt != 0) overlap_err++;
            req_q.push_back(mem_addr);
            req_cyc_q.push_back(cyc);
        end
        if (buf_ld) begin
            ld_q.push_back({buf_row, buf_col, buf_data});
            ld_cyc_q.push_back(cyc);
        end
        if (win_valid && !prev_valid) vrise_q.push_back(cyc);
        prev_valid = win_valid;
        if (buf_shift_en) shift_q.push_back(cyc);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if ((buf_ld && buf_shift_en) || (win_valid && (buf_ld || buf_shift_en))) excl_err++;

        mem_rvalid = inject;
        mem_rdata  = inject ? 32'hDEADBEEF : 32'h0;
        if (pend_cnt == 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mk_data(pend_addr);
        end
        if (pend_cnt > 0) pend_cnt--;
        if (mem_req) begin
            pend_cnt  = int'($urandom_range(lat_max, lat_min));
            pend_addr = mem_addr;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"},         32'(busy), 0);
        check({tag, " done"},         32'(done), 0);
        check({tag, " mem_req"},      32'(mem_req), 0);
        check({tag, " mem_addr"},     32'(mem_addr), 0);
        check({tag, " buf_ld"},       32'(buf_ld), 0);
        check({tag, " buf_shift_en"}, 32'(buf_shift_en), 0);
        check({tag, " buf_row"},      32'(buf_row), 0);
        check({tag, " buf_col"},      32'(buf_col), 0);
        check({tag, " buf_data"},     buf_data, 0);
        check({tag, " table_index"},  32'(buf_table_index), 0);
        check({tag, " win_valid"},    32'(win_valid), 0);
        check({tag, " stall_cnt"},    32'(stall_cnt), 0);
    endtask

    // ------------------------------------------------------------ frame table
    typedef struct {
        logic [15:0] base;
        int          lat_min;
        int          lat_max;
        int          mode;           // 0 plain, 1 backpressure at index 7, 2 start during sweep
        int          exp_reqs;
        int          exp_windows;
        int          exp_shifts;
        logic [15:0] exp_last_addr;
    } frame_vec_t;

    task automatic run_frame(input frame_vec_t v);
        int start_cyc;
        int d0;
        int lim;
        int s0;
        int nb;
        bit bp_done;
        bit sp_done;
        logic [15:0] ea;

        clear_logs();
        lat_min   = v.lat_min;
        lat_max   = v.lat_max;
        win_ready = 1'b1;
        check("idle before start busy", 32'(busy), 0);
        base_addr = v.base;
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        check("first mem_req after start", 32'(mem_req), 1);
        check("busy with first mem_req", 32'(busy), 1);

        d0 = done_cnt; lim = 0; bp_done = 0; sp_done = 0;
        while (done_cnt == d0 && lim < 4000) begin
            if (v.mode == 1 && !bp_done && win_valid && buf_table_index == 4'd7) begin
                s0 = int'(stall_cnt);
                win_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    check("bp index hold", 32'(buf_table_index), 7);
                    check("bp win_valid hold", 32'(win_valid), 1);
                end
                win_ready = 1'b1;
`ifdef BUF_FILL_STALL_CNT_EN
                check("bp stall delta", 32'(int'(stall_cnt) - s0), 5);
`else
                check("stall_cnt disabled", 32'(stall_cnt), 0);
`endif
                bp_done = 1;
            end
            if (v.mode == 2 && !sp_done && win_valid && buf_table_index == 4'd10) begin
                base_addr = 16'h3000;
                start     = 1'b1;
                tick();
                start     = 1'b0;
                base_addr = v.base;
                sp_done   = 1;
            end
            tick();
            lim++;
        end
        check("frame reached done", 32'(done_cnt - d0), 1);
        check("busy during done", 32'(busy), 1);
        tick();
        check("busy low after done", 32'(busy), 0);
        check("done single pulse", 32'(done), 0);
        repeat (4) tick();

        check("request count", 32'(req_q.size()), 32'(v.exp_reqs));
        check("first req cycle", 32'((req_cyc_q.size() > 0) ? req_cyc_q[0] : -1), 32'(start_cyc + 1));
        for (int i = 0; i < req_q.size() && i < v.exp_reqs; i++) begin
            ea = v.base + 16'(i);
            check($sformatf("req addr %0d", i), 32'(req_q[i]), 32'(ea));
        end
        if (req_q.size() > 0) check("last req addr", 32'(req_q[req_q.size()-1]), 32'(v.exp_last_addr));

        check("load count", 32'(ld_q.size()), 32'(v.exp_reqs));
        for (int i = 0; i < ld_q.size() && i < v.exp_reqs; i++) begin
            ea = v.base + 16'(i);
            check($sformatf("ld row %0d", i),  32'(ld_q[i][35:34]), (i < 16) ? 32'(i / 4) : 32'd3);
            check($sformatf("ld col %0d", i),  32'(ld_q[i][33:32]), 32'(i % 4));
            check($sformatf("ld data %0d", i), ld_q[i][31:0], mk_data(ea));
        end

        check("window count", 32'(win_q.size()), 32'(v.exp_windows));
        for (int i = 0; i < win_q.size(); i++)
            check($sformatf("window index %0d", i), 32'(win_q[i]), 32'(3 + (i % 13)));

        check("shift count", 32'(shift_q.size()), 32'(v.exp_shifts));
        for (int i = 0; i < shift_q.size() && i < acc15_q.size(); i++) begin
            check($sformatf("shift after band %0d", i), 32'(shift_q[i]), 32'(acc15_q[i] + 1));
            if (req_cyc_q.size() > 16 + 4 * i)
                check($sformatf("refill req after shift %0d", i), 32'(req_cyc_q[16 + 4 * i]), 32'(shift_q[i] + 1));
        end

        nb = v.exp_shifts + 1;
        for (int k = 0; k < nb && k < vrise_q.size(); k++)
            if (ld_cyc_q.size() > 15 + 4 * k)
                check($sformatf("valid latency band %0d", k), 32'(vrise_q[k]), 32'(ld_cyc_q[15 + 4 * k] + 2));
        if (acc15_q.size() > 0)
            check("done after last window", 32'(done_cyc), 32'(acc15_q[acc15_q.size()-1] + 1));
        check("overlapping reads", 32'(overlap_err), 0);
        check("strobe exclusion", 32'(excl_err), 0);
    endtask

    // ------------------------------------------------------------------ test
    initial begin
        frame_vec_t vecs[4];
        int lim;
        int n_ld;
        int n_req;

        vecs[0] = '{base: 16'h0200, lat_min: 1, lat_max: 1, mode: 0,
                    exp_reqs: 24, exp_windows: 39, exp_shifts: 2, exp_last_addr: 16'h0217};
        vecs[1] = '{base: 16'h0100, lat_min: 1, lat_max: 1, mode: 0,
                    exp_reqs: 24, exp_windows: 39, exp_shifts: 2, exp_last_addr: 16'h0117};
        vecs[2] = '{base: 16'h0000, lat_min: 1, lat_max: 1, mode: 1,
                    exp_reqs: 24, exp_windows: 39, exp_shifts: 2, exp_last_addr: 16'h0017};
        vecs[3] = '{base: 16'hFFF0, lat_min: 1, lat_max: 8, mode: 2,
                    exp_reqs: 24, exp_windows: 39, exp_shifts: 2, exp_last_addr: 16'h0007};

        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        win_ready  = 1'b1;

        // Reset state
        repeat (3) tick();
        check_all_zero("in reset");
        rst = 1'b0;
        tick();
        check_all_zero("after reset");

        // Stray read-valid while idle
        clear_logs();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        repeat (4) tick();
        check("spurious rvalid loads", 32'(ld_q.size()), 0);
        check("spurious rvalid busy", 32'(busy), 0);

        // Reset after the second refill load, with a read still in flight
        clear_logs();
        lat_min = 3; lat_max = 3;
        base_addr = 16'h0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        lim = 0;
        while (ld_q.size() < 18 && lim < 2000) begin
            tick();
            lim++;
        end
        check("reached second refill load", 32'(ld_q.size()), 18);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("mid-refill reset");
        n_ld  = ld_q.size();
        n_req = req_q.size();
        repeat (8) tick();
        check("late rvalid ignored", 32'(ld_q.size()), 32'(n_ld));
        check("no requests after abort", 32'(req_q.size()), 32'(n_req));
        check("idle after abort", 32'(busy), 0);
        check("late rvalid delivered", 32'(pend_cnt), 0);

        // Table-driven frames (the first one is the clean restart at 0x0200)
        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/buffer_fill_ctrl.md
# buffer_fill_ctrl

Upstream controller for the 4-row × 16-byte sliding-window line buffer. It fetches 32-bit image words from word-addressed memory and loads them into the buffer via `ld`/`row`/`col`/`data_in`. It then sweeps `table_index` to present every 4×4 window to the downstream consumer under a valid/ready handshake. Between bands it issues one `shift_en` and refills buffer row 3 with the next image row, until all rows are consumed.

## Interface
Parameters:
- `ADDR_W`, 16: memory word-address width.
- `IMG_ROWS`, 16: image height in rows (each row is 16 bytes = 4 words). Legal range 4..1024.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `start`, in, 1: begin a frame; sampled only in IDLE.
- `base_addr`, in, ADDR_W: word address of row 0 word 0; latched on accepted `start`.
- `busy`, out, 1: high from accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse after the last window is accepted.
- `mem_req`, out, 1: one-cycle read request pulse.
- `mem_addr`, out, ADDR_W: read address, valid with `mem_req`.
- `mem_rvalid`, in, 1: read data valid.
- `mem_rdata`, in, 32: read data; byte [31:24] is the leftmost pixel.
- `buf_ld`, out, 1: buffer load strobe.
- `buf_shift_en`, out, 1: buffer row-shift strobe.
- `buf_row`, out, 2: target buffer row.
- `buf_col`, out, 2: target word column.
- `buf_data`, out, 32: word to load.
- `buf_table_index`, out, 4: rightmost column of the current window.
- `win_valid`, out, 1: buffer window output is valid.
- `win_ready`, in, 1: consumer accepts the window.
- `stall_cnt`, out, 16: performance counter (see Configuration).

## Operation
- Image row r, word c is at `base_addr + 4*r + c`, with modular ADDR_W wrap.
- FSM states: IDLE, FILL, SETTLE, SWEEP, SHIFT, REFILL, DONE.
- **IDLE**
  - `start` → latch `base_addr`, set fetch row = 0, go to FILL.
  - `start` outside IDLE is ignored.
- **Fetch rule (FILL, REFILL)**
  - Exactly one outstanding read.
  - `mem_req` pulses, then nothing until `mem_rvalid`; the next `mem_req` may issue in the cycle after `mem_rvalid`.
  - `mem_rvalid` with no outstanding read is ignored.
- **FILL**
  - Fetch 16 words, image rows 0..3, words 0..3 in order.
  - Each returned word loads buffer row = image row, col = word index.
  - After the 16th load → SETTLE.
- **REFILL**
  - Fetch the 4 words of the next image row into buffer row 3, cols 0..3.
  - After the 4th load → SETTLE.
- **SETTLE**: one cycle, so the last load is visible in the buffer. Then set `buf_table_index` = 3 and go to SWEEP.
- **SWEEP**
  - `win_valid` is high.
  - On `win_valid && win_ready`: if index < 15, increment; if index = 15, end the band.
  - 13 windows per band (index 3..15).
  - `buf_table_index` and `win_valid` hold stable while `win_ready` is low.
- **End of band**
  - If the next image row < IMG_ROWS → SHIFT.
  - Otherwise → DONE.
- **SHIFT**: `buf_shift_en` high for exactly one cycle, then REFILL.
- **DONE**: `done` pulses for one cycle, `busy` drops, return to IDLE.
- **Counts**: total bands = IMG_ROWS − 3; total windows = 13·(IMG_ROWS − 3).
- **Mutual exclusion**: `buf_ld` and `buf_shift_en` are never high in the same cycle. `win_valid` is never high with either of them.

## Timing
- **Reset values**: all outputs are 0, including `buf_table_index` and `stall_cnt`. State is IDLE and any outstanding-read flag is cleared.
- **Start**: first `mem_req` issues the cycle after `start` is accepted; `busy` rises in the same cycle as that `mem_req`.
- **Load path**
  - `buf_ld` and `buf_data`/`buf_row`/`buf_col` are registered: `buf_ld` is high exactly one cycle after each `mem_rvalid`.
  - `buf_data` equals the `mem_rdata` sampled on that `mem_rvalid`.
- **Fill-to-window latency**: last `buf_ld` at cycle t → SETTLE at t+1 → `win_valid` at t+2.
- **Shift timing**
  - Last window accepted at cycle t → `buf_shift_en` at t+1.
  - Refill `mem_req` at t+2.
- **Done timing**: the final window accepted at cycle t → `done` at t+1; `busy` is low from t+2.
- **Reset mid-operation**
  - A synchronous `rst` aborts to IDLE in the next cycle with all outputs 0.
  - A `mem_rvalid` arriving after reset is ignored.
- **Memory latency**: any latency ≥ 1 cycle is legal.

## Configuration
- `BUF_FILL_STALL_CNT_EN` defined:
  - `stall_cnt` increments in every cycle with `win_valid && !win_ready`, or with a read outstanding and `mem_rvalid` low.
  - It saturates at 16'hFFFF and clears on `rst` and on accepted `start`.
- `BUF_FILL_STALL_CNT_EN` undefined: `stall_cnt` is constant 0 and no counter logic is built.

## Test plan
- **Basic frame**
  - Stimulus: IMG_ROWS=4, base_addr=0x0100, memory latency 1, `win_ready` tied 1.
  - Expected: 16 loads at addresses 0x0100..0x010F with row/col = (a>>2)&3, a&3; 13 windows with index 3..15; zero `buf_shift_en`; `done` one cycle after index 15 is accepted.
- **Multi-band**
  - Stimulus: IMG_ROWS=6, base_addr=0.
  - Expected: 3 bands; 2 `buf_shift_en` pulses; each followed by 4 loads into row 3 from addresses 16..19, then 20..23; 39 windows in total.
- **Backpressure**
  - Stimulus: `win_ready` low for 5 cycles at index 7.
  - Expected: index and `win_valid` hold at 7; with the macro defined, `stall_cnt` increases by exactly 5 from that interval.
- **Variable latency and spurious valid**
  - Stimulus: memory latency randomised 1..8; an extra `mem_rvalid` injected while idle.
  - Expected: one outstanding read at a time; loads in order; the spurious valid produces no `buf_ld`.
- **Reset mid-refill**
  - Stimulus: assert `rst` after the 2nd refill load.
  - Expected: next cycle all outputs 0 and state IDLE; a late `mem_rvalid` is ignored; a new `start` with base_addr=0x0200 runs a clean frame.
- **Start while busy**
  - Stimulus: pulse `start` during SWEEP.
  - Expected: ignored; the frame completes with the original address sequence.
